// File: rtl/rsa_mont_param.sv
// Montgomery modular exponentiation: cypher = message_in^exponent mod modulus.
// Bit-serial radix-2 Montgomery products, on-chip R^2 precompute, left-to-right square/multiply.
module rsa_mont_param #(
    parameter int WIDTH     = 2048,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [WIDTH-1:0]     message_in,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic [WIDTH-1:0]     cypher,
    output logic                 done,
    output logic                 busy,
    output logic                 error
);
    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(2 * WIDTH + 1);
    localparam int BW = $clog2(EXP_WIDTH + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_R2        = 4'd2;
    localparam logic [3:0] S_MONT_X    = 4'd3;
    localparam logic [3:0] S_MONT_ONE  = 4'd4;
    localparam logic [3:0] S_SCAN      = 4'd5;
    localparam logic [3:0] S_SQR       = 4'd6;
    localparam logic [3:0] S_MUL       = 4'd7;
    localparam logic [3:0] S_FROM_MONT = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;

    logic [3:0]           state_q, state_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     mm_a_q, mm_a_d;
    logic [WIDTH-1:0]     mm_b_q, mm_b_d;
    logic [TW-1:0]        t_q, t_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bits_q, bits_d;
    logic [WIDTH-1:0]     r2_q, r2_d;
    logic [WIDTH-1:0]     xm_q, xm_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     cypher_q, cypher_d;
    logic                 error_q, error_d;

    logic [TW-1:0]    n_ext, t_sum, t_odd, t_iter, t_red, iter_red, r_dbl, r_next;
    logic [WIDTH-1:0] mm_res;
    logic             adv;
    logic [WIDTH-1:0] adv_val;
    logic             unused_hi;

    // One Montgomery iteration, the final conditional subtract, and one R^2 doubling step.
    always_comb begin
        n_ext    = {2'b00, n_q};
        t_sum    = t_q + (mm_a_q[0] ? {2'b00, mm_b_q} : '0);
        t_odd    = t_sum[0] ? t_sum + n_ext : t_sum;
        t_iter   = t_odd >> 1;
        t_red    = (t_q >= n_ext) ? t_q - n_ext : t_q;
        iter_red = (t_iter >= n_ext) ? t_iter - n_ext : t_iter;
        r_dbl    = {t_q[TW-2:0], 1'b0};
        r_next   = (r_dbl >= n_ext) ? r_dbl - n_ext : r_dbl;
        mm_res   = t_red[WIDTH-1:0];
    end

    assign unused_hi = ^{t_red[TW-1:WIDTH], iter_red[TW-1:WIDTH], r_next[TW-1:WIDTH]};

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        e_d      = e_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        r2_d     = r2_q;
        xm_d     = xm_q;
        acc_d    = acc_q;
        cypher_d = cypher_q;
        error_d  = error_q;
        adv      = 1'b0;
        adv_val  = acc_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    n_d     = modulus;
                    e_d     = exponent;
                    mm_a_d  = message_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!n_q[0] || n_q < WIDTH'(3) || mm_a_q >= n_q) begin
                    cypher_d = '0;
                    error_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    t_d     = TW'(1);
                    cnt_d   = CW'(2 * WIDTH);
                    state_d = S_R2;
                end
            end
            S_R2: begin
                t_d   = r_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    r2_d    = r_next[WIDTH-1:0];
                    mm_b_d  = r_next[WIDTH-1:0];
                    t_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_MONT_X;
                end
            end
            S_MONT_X, S_MONT_ONE, S_SQR, S_MUL: begin
                if (cnt_q != '0) begin
                    t_d    = t_iter;
                    mm_a_d = mm_a_q >> 1;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    t_d   = '0;
                    cnt_d = CW'(WIDTH);
                    case (state_q)
                        S_MONT_X: begin
                            xm_d    = mm_res;
                            mm_a_d  = r2_q;
                            mm_b_d  = WIDTH'(1);
                            state_d = S_MONT_ONE;
                        end
                        S_MONT_ONE: begin
                            acc_d   = mm_res;
                            bits_d  = BW'(EXP_WIDTH);
                            state_d = S_SCAN;
                        end
                        S_SQR: begin
                            acc_d = mm_res;
                            if (e_q[EXP_WIDTH-1]) begin
                                mm_a_d  = mm_res;
                                mm_b_d  = xm_q;
                                state_d = S_MUL;
                            end else begin
                                adv     = 1'b1;
                                adv_val = mm_res;
                            end
                        end
                        default: begin
                            acc_d   = mm_res;
                            adv     = 1'b1;
                            adv_val = mm_res;
                        end
                    endcase
                end
            end
            S_SCAN: begin
                // The leading set bit loads xm directly instead of squaring 1.
                if (e_q[EXP_WIDTH-1]) begin
                    acc_d   = xm_q;
                    adv     = 1'b1;
                    adv_val = xm_q;
                end else if (bits_q == BW'(1)) begin
                    adv     = 1'b1;
                    adv_val = acc_q;
                end else begin
                    e_d    = e_q << 1;
                    bits_d = bits_q - BW'(1);
                end
            end
            S_FROM_MONT: begin
                t_d    = t_iter;
                mm_a_d = mm_a_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    cypher_d = iter_red[WIDTH-1:0];
                    error_d  = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Retire the current exponent bit and start the next product.
        if (adv) begin
            e_d    = e_q << 1;
            bits_d = bits_q - BW'(1);
            t_d    = '0;
            cnt_d  = CW'(WIDTH);
            mm_a_d = adv_val;
            if (bits_q == BW'(1)) begin
                mm_b_d  = WIDTH'(1);
                state_d = S_FROM_MONT;
            end else begin
                mm_b_d  = adv_val;
                state_d = S_SQR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            e_q      <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            bits_q   <= '0;
            r2_q     <= '0;
            xm_q     <= '0;
            acc_q    <= '0;
            cypher_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            e_q      <= e_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            r2_q     <= r2_d;
            xm_q     <= xm_d;
            acc_q    <= acc_d;
            cypher_q <= cypher_d;
            error_q  <= error_d;
        end
    end

    assign cypher = cypher_q;
    assign error  = error_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_rsa_mont_param.sv
// Self-checking bench for rsa_mont_param: directed and random operations on a 16-bit
// instance against a plain-arithmetic model, plus a 2048-bit smoke test.
module tb_rsa_mont_param;
    localparam int W  = 16;
    localparam int WB = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, go, go_b;
    logic [W-1:0]  x_in, e_in, n_in, cyp;
    logic          done, busy, err;
    logic [WB-1:0] xb, eb, nb, cyp_b;
    logic          done_b, busy_b, err_b;

    int checks = 0;
    int errors = 0;

    rsa_mont_param #(.WIDTH(W), .EXP_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .go(go), .message_in(x_in), .exponent(e_in),
        .modulus(n_in), .cypher(cyp), .done(done), .busy(busy), .error(err)
    );

    rsa_mont_param #(.WIDTH(WB)) dut_big (
        .clk(clk), .rst(rst), .go(go_b), .message_in(xb), .exponent(eb),
        .modulus(nb), .cypher(cyp_b), .done(done_b), .busy(busy_b), .error(err_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_modexp(longint x, longint e, longint n, int ew);
        longint r;
        r = 1 % n;
        for (int i = ew - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (((e >> i) & 1) == 1) r = (r * x) % n;
        end
        return r;
    endfunction

    function automatic int ref_latency(longint e, int w, int ew);
        int p, s, h;
        p = -1;
        h = 0;
        for (int i = 0; i < ew && i < 63; i++)
            if (((e >> i) & 1) == 1) p = i;
        if (p < 0) begin
            s = ew;
            p = 0;
        end else begin
            s = ew - p;
            for (int i = 0; i < p; i++)
                if (((e >> i) & 1) == 1) h++;
        end
        return 1 + 2 * w + 2 * (w + 1) + s + (p + h) * (w + 1) + (w + 1);
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] e, input logic [15:0] n,
                          input int midgo_at, input string tag);
        int      cyc, busy_low, exp_t;
        bit      seen, valid;
        longint  exp_c;
        logic [15:0] got_c;
        logic    got_e;
        valid = n[0] && (n >= 16'd3) && (x < n);
        exp_c = valid ? ref_modexp(longint'(x), longint'(e), longint'(n), W) : 0;
        exp_t = valid ? ref_latency(longint'(e), W, W) : 2;
        @(negedge clk);
        x_in = x; e_in = e; n_in = n; go = 1'b1;
        cyc = 0; seen = 0; busy_low = 0; got_c = '0; got_e = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                go = 1'b0;
                x_in = 16'($urandom); e_in = 16'($urandom); n_in = 16'($urandom);
            end
            if (midgo_at > 0 && cyc == midgo_at) go = 1'b1;
            if (midgo_at > 0 && cyc == midgo_at + 1) go = 1'b0;
            if (!busy) busy_low++;
            if (done) begin
                seen = 1;
                got_c = cyp;
                got_e = err;
            end
        end
        go = 1'b0;
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(exp_t));
        chk({tag, " cypher"}, 64'(got_c), 64'(exp_c));
        chk({tag, " error"}, 64'(got_e), 64'(!valid));
        chk({tag, " busy_gap"}, 64'(busy_low), 64'd0);
        @(negedge clk);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " done_after"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [15:0] rn, rx, re;
        int cyc, done_cnt;
        bit seen;

        rst = 1'b1; go = 1'b1; go_b = 1'b1;
        x_in = 16'd8; e_in = 16'd13; n_in = 16'd77;
        xb = WB'(8); eb = WB'(13); nb = WB'(77);
        repeat (3) @(negedge clk);
        chk("reset busy (go held)", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset cypher", 64'(cyp), 64'd0);
        chk("reset error", 64'(err), 64'd0);
        chk("reset big busy", 64'(busy_b), 64'd0);
        go = 1'b0; go_b = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("idle busy", 64'(busy), 64'd0);

        run_op(16'd8,  16'd13,  16'd77,  0, "x8e13n77");
        run_op(16'd50, 16'd37,  16'd77,  0, "x50e37n77");
        run_op(16'd25, 16'd7,   16'd143, 0, "x25e7n143");
        run_op(16'd64, 16'd103, 16'd143, 0, "x64e103n143");
        run_op(16'd8,  16'd13,  16'd78,  0, "even_n");
        run_op(16'd80, 16'd13,  16'd77,  0, "x_ge_n");
        run_op(16'd2,  16'd0,   16'd77,  0, "e_zero");
        run_op(16'd0,  16'd5,   16'd77,  0, "x_zero");
        run_op(16'd8,  16'd13,  16'd77, 20, "mid_go");

        // Abort a run with rst at cycle 40.
        @(negedge clk);
        x_in = 16'd8; e_in = 16'd13; n_in = 16'd77; go = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) go = 1'b0;
        end
        chk("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort cypher", 64'(cyp), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort error", 64'(err), 64'd0);
        done_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort no done", 64'(done_cnt), 64'd0);
        run_op(16'd8, 16'd13, 16'd77, 0, "after_abort");

        for (int k = 0; k < 12; k++) begin
            rn = 16'($urandom_range(3, 65535)) | 16'd1;
            case (k % 4)
                0: re = 16'($urandom);
                1: re = 16'($urandom_range(0, 15));
                2: re = 16'd1 << $urandom_range(0, 15);
                default: re = 16'($urandom);
            endcase
            rx = 16'($urandom_range(0, int'(rn) - 1));
            if (k == 5) rx = rn;
            if (k == 7) begin rn = 16'd1; rx = 16'd0; end
            if (k == 9) rn = rn & 16'hFFFE;
            run_op(rx, re, rn, 0, $sformatf("rand%0d", k));
        end

        // Full-width smoke test.
        @(negedge clk);
        xb = WB'(8); eb = WB'(13); nb = WB'(77); go_b = 1'b1;
        cyc = 0; seen = 0;
        while (!seen && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) go_b = 1'b0;
            if (done_b) seen = 1;
        end
        go_b = 1'b0;
        chk("big done_seen", 64'(seen), 64'd1);
        chk("big latency", 64'(cyc), 64'(ref_latency(13, WB, WB)));
        chk("big cypher_lo", cyp_b[63:0], 64'd50);
        chk("big cypher_hi_zero", 64'(|cyp_b[WB-1:64]), 64'd0);
        chk("big error", 64'(err_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
